// File: rtl/uba_dma_tst.sv
// uba_dma_tst: Unibus-side test device on the KS10 IO bus.
// Serves CSR/SRC/DST/CNT as a bus target and copies CNT words from SRC to DST
// through the UBA as a DMA initiator.
// Raises a BR interrupt on completion and answers the WRU vector poll.
// KS10 bit n of a bus word is vector index 35-n.
module uba_dma_tst #(
   parameter logic [17:0] BASE    = 18'o760100,
   parameter logic [3:0]  UBANUM  = 4'd3,
   parameter int unsigned BR      = 4,
   parameter logic [17:0] VECT    = 18'o000300,
   parameter int unsigned TIMEOUT = 1023
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        devRESET,
   output logic        devACLO,
   input  logic        devREQI,
   input  logic        devACKI,
   input  logic [35:0] devADDRI,
   input  logic [35:0] devDATAI,
   output logic        devREQO,
   output logic        devACKO,
   output logic [35:0] devADDRO,
   output logic [35:0] devDATAO,
   output logic [7:4]  devINTRO
);

   localparam int unsigned TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

   // Vector indices of the KS10 address-word flag bits
   localparam int unsigned B_READ  = 32;
   localparam int unsigned B_WRITE = 30;
   localparam int unsigned B_IO    = 29;
   localparam int unsigned B_WRU   = 28;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RD,
      ST_WR,
      ST_FIN
   } state_t;

   state_t        state_q, state_d;
   logic [17:0]   src_q, src_d;
   logic [17:0]   dst_q, dst_d;
   logic [15:0]   cnt_q, cnt_d;
   logic [35:0]   hold_q, hold_d;
   logic          ie_q, ie_d;
   logic          done_q, done_d;
   logic          err_q, err_d;
   logic          req_q, req_d;
   logic          int_q, int_d;
   logic [TW-1:0] tmo_q, tmo_d;

   logic          uba_match;
   logic [16:0]   reg_off;
   logic [1:0]    reg_idx;
   logic          sel;
   logic          wr_acc;
   logic          wruhit;
   logic          busy;
   logic          ack_ok;
   logic          go;
   logic [17:0]   rd_val;
   logic          unused_ok;

   assign uba_match = (devADDRI[21:18] == UBANUM);
   assign reg_off   = devADDRI[17:1] - BASE[17:1];
   assign reg_idx   = reg_off[1:0];
   assign sel       = devREQI & devADDRI[B_IO] & uba_match &
                      (reg_off < 17'd4) & ~devADDRI[0];
   assign wr_acc    = sel & devADDRI[B_WRITE];
   assign wruhit    = devREQI & devADDRI[B_WRU] & uba_match & done_q & ie_q;
   assign busy      = (state_q != ST_IDLE);
   assign ack_ok    = devACKI & req_q;

   assign devACLO   = 1'b0;
   assign devACKO   = sel | wruhit;
   assign devREQO   = req_q;

   assign unused_ok = ^{devADDRI[35:33], devADDRI[31], devADDRI[27:22]};

   // Register readback mux
   always_comb begin
      rd_val = '0;
      case (reg_idx)
         2'd0: rd_val = {2'b00, err_q, 7'b0, done_q, ie_q, 5'b0, busy};
         2'd1: rd_val = src_q;
         2'd2: rd_val = dst_q;
         default: rd_val = {2'b00, cnt_q};
      endcase
   end

   // Register writes first, then the DMA FSM so that FSM status sets win
   always_comb begin
      state_d = state_q;
      src_d   = src_q;
      dst_d   = dst_q;
      cnt_d   = cnt_q;
      hold_d  = hold_q;
      ie_d    = ie_q;
      done_d  = done_q;
      err_d   = err_q;
      tmo_d   = tmo_q;
      go      = 1'b0;

      if (wr_acc) begin
         case (reg_idx)
            2'd0: begin
               ie_d = devDATAI[6];
               if (devDATAI[7]) done_d = 1'b0;
               if (devDATAI[15]) err_d = 1'b0;
               if (!busy && devDATAI[0]) go = 1'b1;
            end
            2'd1: if (!busy) src_d = devDATAI[17:0];
            2'd2: if (!busy) dst_d = devDATAI[17:0];
            default: if (!busy) cnt_d = devDATAI[15:0];
         endcase
      end

      case (state_q)
         ST_IDLE: begin
            tmo_d = '0;
            if (go) begin
               done_d  = 1'b0;
               err_d   = 1'b0;
               state_d = (cnt_q != 16'd0) ? ST_RD : ST_FIN;
            end
         end
         ST_RD: begin
            if (ack_ok) begin
               hold_d  = devDATAI;
               src_d   = src_q + 18'd2;
               tmo_d   = '0;
               state_d = ST_WR;
            end else if (tmo_q == TMO_LAST) begin
               err_d   = 1'b1;
               done_d  = 1'b1;
               state_d = ST_IDLE;
            end else begin
               tmo_d = tmo_q + TW'(1);
            end
         end
         ST_WR: begin
            if (ack_ok) begin
               dst_d   = dst_q + 18'd2;
               cnt_d   = cnt_q - 16'd1;
               tmo_d   = '0;
               state_d = (cnt_q == 16'd1) ? ST_FIN : ST_RD;
            end else if (tmo_q == TMO_LAST) begin
               err_d   = 1'b1;
               done_d  = 1'b1;
               state_d = ST_IDLE;
            end else begin
               tmo_d = tmo_q + TW'(1);
            end
         end
         default: begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
         end
      endcase
   end

   // Request is held low for the cycle after an ack so the UBA never sees a stale request
   always_comb begin
      req_d = ((state_d == ST_RD) || (state_d == ST_WR)) && !ack_ok;
      int_d = done_d & ie_d;
   end

   // State and register update with synchronous reset
   always_ff @(posedge clk) begin
      if (rst || devRESET) begin
         state_q <= ST_IDLE;
         src_q   <= '0;
         dst_q   <= '0;
         cnt_q   <= '0;
         hold_q  <= '0;
         ie_q    <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         req_q   <= 1'b0;
         int_q   <= 1'b0;
         tmo_q   <= '0;
      end else begin
         state_q <= state_d;
         src_q   <= src_d;
         dst_q   <= dst_d;
         cnt_q   <= cnt_d;
         hold_q  <= hold_d;
         ie_q    <= ie_d;
         done_q  <= done_d;
         err_q   <= err_d;
         req_q   <= req_d;
         int_q   <= int_d;
         tmo_q   <= tmo_d;
      end
   end

   // DMA address word for the current transfer phase
   always_comb begin
      devADDRO = '0;
      case (state_q)
         ST_RD: begin
            devADDRO[B_READ] = 1'b1;
            devADDRO[B_IO]   = 1'b1;
            devADDRO[21:18]  = UBANUM;
            devADDRO[17:0]   = src_q;
         end
         ST_WR: begin
            devADDRO[B_WRITE] = 1'b1;
            devADDRO[B_IO]    = 1'b1;
            devADDRO[21:18]   = UBANUM;
            devADDRO[17:0]    = dst_q;
         end
         default: devADDRO = '0;
      endcase
   end

   // Data out: target read or vector, else DMA write data, else zero
   always_comb begin
      devDATAO = '0;
      if (sel)
         devDATAO[17:0] = rd_val;
      else if (wruhit)
         devDATAO[17:0] = VECT;
      else if (state_q == ST_WR)
         devDATAO = hold_q;
   end

   // Interrupt request on the configured BR line only
   always_comb begin
      devINTRO     = '0;
      devINTRO[BR] = int_q;
   end

endmodule

// File: tb/tb_uba_dma_tst.sv
// Bench for uba_dma_tst: register access, DMA copy against a UBA model with a
// write scoreboard, interrupt/WRU, zero count, timeout and mid-transfer reset.
module tb_uba_dma_tst;

   localparam logic [17:0] BASE = 18'o760100;

   logic        clk;
   logic        rst;
   logic        devRESET;
   logic        devACLO;
   logic        devREQI;
   logic        devACKI;
   logic [35:0] devADDRI;
   logic [35:0] devDATAI;
   logic        devREQO;
   logic        devACKO;
   logic [35:0] devADDRO;
   logic [35:0] devDATAO;
   logic [7:4]  devINTRO;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   typedef struct {
      logic [35:0] addr;
      logic [35:0] data;
   } wr_exp_t;

   wr_exp_t     sb[$];
   logic [35:0] mem[int];
   logic [17:0] exp_src;
   logic [17:0] exp_dst;

   uba_dma_tst #(
      .BASE(18'o760100),
      .UBANUM(4'd3),
      .BR(4),
      .VECT(18'o000300),
      .TIMEOUT(1023)
   ) dut (
      .clk(clk),
      .rst(rst),
      .devRESET(devRESET),
      .devACLO(devACLO),
      .devREQI(devREQI),
      .devACKI(devACKI),
      .devADDRI(devADDRI),
      .devDATAI(devDATAI),
      .devREQO(devREQO),
      .devACKO(devACKO),
      .devADDRO(devADDRO),
      .devDATAO(devDATAO),
      .devINTRO(devINTRO)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [35:0] got, input logic [35:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %o expected %o", tag, got, exp);
      end
   endtask

   // Bus word: READ=bit3, WRITE=bit5, IO=bit6, WRU=bit7, UBA=bits14:17, addr=bits18:35
   function automatic logic [35:0] busw(input bit rd, input bit wr, input bit io,
                                        input bit wru, input logic [3:0] uba,
                                        input logic [17:0] a);
      logic [35:0] v;
      v        = '0;
      v[32]    = rd;
      v[30]    = wr;
      v[29]    = io;
      v[28]    = wru;
      v[21:18] = uba;
      v[17:0]  = a;
      return v;
   endfunction

   task automatic reg_wr(input int unsigned idx, input logic [17:0] val);
      @(negedge clk);
      devREQI  = 1'b1;
      devADDRI = busw(0, 1, 1, 0, 4'd3, BASE + 18'(2 * idx));
      devDATAI = {18'b0, val};
      #1;
      chk("wr_ack", {35'b0, devACKO}, 36'd1);
      @(posedge clk);
      #1;
      devREQI  = 1'b0;
      devADDRI = '0;
      devDATAI = '0;
   endtask

   task automatic reg_rd(input string tag, input int unsigned idx, input logic [17:0] exp);
      @(negedge clk);
      devREQI  = 1'b1;
      devADDRI = busw(1, 0, 1, 0, 4'd3, BASE + 18'(2 * idx));
      #1;
      chk("rd_ack", {35'b0, devACKO}, 36'd1);
      chk(tag, devDATAO, {18'b0, exp});
      @(posedge clk);
      #1;
      devREQI  = 1'b0;
      devADDRI = '0;
   endtask

   // UBA model: acks a request on its 2nd cycle; reads return mem[], writes are scored
   task automatic run_uba(input int unsigned n_words, input bit wait_idle, input int unsigned budget);
      int unsigned reqc   = 0;
      int unsigned writes = 0;
      int unsigned idle   = 0;
      int unsigned cyc    = 0;
      bit          fin    = 0;
      wr_exp_t     e;
      logic [35:0] d;
      while (!fin) begin
         @(negedge clk);
         cyc++;
         devACKI = 1'b0;
         if (!wait_idle && writes >= n_words) begin
            fin = 1;
         end else begin
            if (devREQO) begin
               idle = 0;
               reqc++;
               if (reqc >= 2) begin
                  reqc    = 0;
                  devACKI = 1'b1;
                  if (devADDRO[32]) begin
                     chk("rd_addr", devADDRO, busw(1, 0, 1, 0, 4'd3, exp_src));
                     d        = mem.exists(int'(exp_src)) ? mem[int'(exp_src)] : '0;
                     devDATAI = d;
                     e.addr   = busw(0, 1, 1, 0, 4'd3, exp_dst);
                     e.data   = d;
                     sb.push_back(e);
                     exp_src  = exp_src + 18'd2;
                     exp_dst  = exp_dst + 18'd2;
                  end else begin
                     if (sb.size() == 0) begin
                        chk("sb_underflow", devADDRO, '0);
                     end else begin
                        e = sb.pop_front();
                        chk("wr_addr", devADDRO, e.addr);
                        chk("wr_data", devDATAO, e.data);
                     end
                     writes++;
                  end
               end
            end else begin
               reqc = 0;
               idle++;
            end
            if (wait_idle && writes >= n_words && idle >= 4) fin = 1;
            if (!fin && cyc >= budget) begin
               chk("uba_words", 36'(writes), 36'(n_words));
               chk("uba_idle", {35'b0, devREQO}, '0);
               fin = 1;
            end
         end
      end
      devACKI = 1'b0;
   endtask

   initial begin
      time         t0;
      time         t1;
      int unsigned guard;

      rst      = 1'b1;
      devRESET = 1'b0;
      devREQI  = 1'b0;
      devACKI  = 1'b0;
      devADDRI = '0;
      devDATAI = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // Reset state
      @(negedge clk);
      chk("rst_req", {35'b0, devREQO}, '0);
      chk("rst_intr", {32'b0, devINTRO}, '0);
      chk("rst_addr", devADDRO, '0);
      chk("rst_data", devDATAO, '0);
      chk("rst_aclo", {35'b0, devACLO}, '0);

      // Register read/write
      reg_wr(1, 18'o1000);
      reg_wr(2, 18'o2000);
      reg_wr(3, 18'd3);
      reg_rd("src_rb", 1, 18'o1000);
      reg_rd("dst_rb", 2, 18'o2000);
      reg_rd("cnt_rb", 3, 18'd3);
      reg_rd("csr_idle", 0, 18'o0);
      @(negedge clk);
      devREQI  = 1'b1;
      devADDRI = busw(1, 0, 1, 0, 4'd1, BASE);
      #1 chk("uba1_noack", {35'b0, devACKO}, '0);
      @(posedge clk);
      #1 devREQI = 1'b0;
      devADDRI = '0;

      // Three-word copy
      mem[int'(18'o1000)] = 36'd1;
      mem[int'(18'o1002)] = 36'd2;
      mem[int'(18'o1004)] = 36'd3;
      exp_src = 18'o1000;
      exp_dst = 18'o2000;
      reg_wr(0, 18'o1);
      run_uba(3, 1, 300);
      chk("sb_empty", 36'(sb.size()), '0);
      reg_rd("src_end", 1, 18'o1006);
      reg_rd("dst_end", 2, 18'o2006);
      reg_rd("cnt_end", 3, 18'd0);
      reg_rd("csr_done", 0, 18'o200);

      // WRU with IE clear gets no ack
      @(negedge clk);
      devREQI  = 1'b1;
      devADDRI = busw(0, 0, 0, 1, 4'd3, 18'o0);
      #1 chk("wru_noie", {35'b0, devACKO}, '0);
      @(posedge clk);
      #1 devREQI = 1'b0;
      devADDRI = '0;

      // Interrupt: IE=1, one-word copy
      mem[int'(18'o3000)] = 36'o123456701234;
      exp_src = 18'o3000;
      exp_dst = 18'o4000;
      reg_wr(1, 18'o3000);
      reg_wr(2, 18'o4000);
      reg_wr(3, 18'd1);
      reg_wr(0, 18'o101);
      run_uba(1, 1, 200);
      chk("sb_empty1", 36'(sb.size()), '0);
      @(negedge clk);
      chk("intr_on", {32'b0, devINTRO}, 36'd1);
      @(negedge clk);
      devREQI  = 1'b1;
      devADDRI = busw(0, 0, 0, 1, 4'd3, 18'o0);
      #1;
      chk("wru_ack", {35'b0, devACKO}, 36'd1);
      chk("wru_vec", devDATAO, 36'o300);
      @(posedge clk);
      #1 devREQI = 1'b0;
      devADDRI = '0;
      reg_rd("csr_after_wru", 0, 18'o300);
      reg_wr(0, 18'o300);
      @(negedge clk);
      chk("intr_off", {32'b0, devINTRO}, '0);
      reg_rd("csr_ie_only", 0, 18'o100);

      // Zero count: FIN then DONE, never a request
      reg_wr(0, 18'o1);
      chk("zero_req0", {35'b0, devREQO}, '0);
      reg_rd("zero_fin", 0, 18'o1);
      chk("zero_req1", {35'b0, devREQO}, '0);
      reg_rd("zero_done", 0, 18'o200);
      chk("zero_intr", {32'b0, devINTRO}, '0);

      // Timeout: no acks; writes during busy are ignored
      reg_wr(1, 18'o5000);
      reg_wr(2, 18'o6000);
      reg_wr(3, 18'd2);
      reg_wr(0, 18'o1);
      t0 = $time;
      reg_wr(1, 18'o7000);
      reg_wr(0, 18'o1);
      guard = 0;
      do begin
         @(negedge clk);
         guard++;
      end while (devREQO && guard < 1200);
      t1 = $time;
      chk("tmo_cycles", 36'((t1 - t0 - 4) / 10), 36'd1023);
      chk("tmo_req", {35'b0, devREQO}, '0);
      reg_rd("tmo_csr", 0, 18'o100200);
      reg_rd("tmo_src", 1, 18'o5000);
      reg_rd("tmo_dst", 2, 18'o6000);
      reg_rd("tmo_cnt", 3, 18'd2);

      // Reset mid-DMA after two of five words
      mem[int'(18'o1006)] = 36'd4;
      mem[int'(18'o1010)] = 36'd5;
      exp_src = 18'o1000;
      exp_dst = 18'o2000;
      reg_wr(1, 18'o1000);
      reg_wr(2, 18'o2000);
      reg_wr(3, 18'd5);
      reg_wr(0, 18'o101);
      run_uba(2, 0, 200);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("mid_rst_req", {35'b0, devREQO}, '0);
      chk("mid_rst_addr", devADDRO, '0);
      chk("mid_rst_data", devDATAO, '0);
      chk("mid_rst_intr", {32'b0, devINTRO}, '0);
      reg_rd("mid_rst_csr", 0, 18'o0);
      reg_rd("mid_rst_src", 1, 18'o0);
      reg_rd("mid_rst_dst", 2, 18'o0);
      reg_rd("mid_rst_cnt", 3, 18'o0);
      repeat (4) begin
         @(negedge clk);
         chk("mid_rst_quiet", {35'b0, devREQO}, '0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/uba_dma_tst.md
Name: uba_dma_tst

Overview:
- Unibus-side test device implementing the `device` end of the KS10 IO bus.
- Responds as a target to UBA register reads and writes: CSR, SRC, DST and CNT.
- Acts as a DMA initiator toward the UBA: copies CNT 36-bit words from SRC to DST through the UBA, one read and one write per word.
- Raises a bus-request interrupt on completion and answers the UBA interrupt-vector poll (WRU).

Parameters:
- BASE, 18'o760100, Unibus byte address of CSR; SRC at +2, DST at +4, CNT at +6.
- UBANUM, 4'd3, UBA number matched in devADDRI[14:17] and driven in devADDRO[14:17].
- BR, 4, devINTRO bit used for the interrupt (legal values 4..7).
- VECT, 18'o000300, vector returned on WRU.
- TIMEOUT, 1023, cycles to wait for devACKI before flagging error.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- devRESET  input  1  device reset, synchronous, same effect as rst
- devACLO  output  1  power fail; constant 0
- devREQI  input  1  UBA request to device
- devACKI  input  1  UBA acknowledge of device DMA request
- devADDRI  input  36  [3]=READ, [5]=WRITE, [6]=IO, [7]=WRU, [14:17]=UBA#, [18:35]=address
- devDATAI  input  36  write data / DMA read data
- devREQO  output  1  DMA request
- devACKO  output  1  acknowledge of UBA request
- devADDRO  output  36  DMA address, same field layout as devADDRI
- devDATAO  output  36  read data / vector / DMA write data
- devINTRO  output  4 ([7:4])  interrupt request

Behaviour:
- Clock and reset:
  - Single clock `clk`; reset is synchronous and active-high on `rst`.
  - `rst` or devRESET clears all registers, sets the FSM to IDLE and aborts any DMA immediately. No partial writes complete.
  - All outputs read 0 in the cycle after reset.
- Bit numbering: register bit n maps to devDATA[35-n].
- Register decode:
  - sel = devREQI & IO & (UBA# == UBANUM) & (addr[18:34] selects BASE..BASE+6) & (addr[35] == 0).
  - devACKO = sel | wruhit. It is combinational, in the same cycle as devREQI.
  - Read: devDATAO[18:35] = selected register zero-extended; devDATAO[0:17] = 0.
  - Write: takes effect at the next clock edge.
- CSR bits (other bits read 0):
  - 0 GO/BUSY: write 1 in IDLE starts DMA. Reads 1 while the FSM is not IDLE.
  - 6 IE: read/write.
  - 7 DONE: read-only set; write-1-to-clear. Cleared automatically on GO.
  - 15 ERR: set on timeout; write-1-to-clear; cleared on GO.
- Writes while busy:
  - SRC, DST and CNT writes are ignored.
  - CSR writes update only IE and the W1C bits; a GO write is ignored.
- SRC, DST: 18-bit byte addresses. CNT: 16-bit word count.
- FSM states:
  - IDLE: on GO, go to RD if CNT != 0, otherwise go to FIN.
  - RD:
    - Drives devREQO = 1, devADDRO = {READ, IO, UBA#, SRC}.
    - On devACKI: HOLD <= devDATAI, SRC <= SRC + 2 (mod 2^18), go to WR.
  - WR:
    - Drives devREQO = 1, devADDRO = {WRITE, IO, UBA#, DST}, devDATAO = HOLD.
    - On devACKI: DST <= DST + 2, CNT <= CNT - 1.
    - Next state: FIN if CNT was 1, otherwise RD.
  - FIN: DONE <= 1, go to IDLE. Occupies exactly one cycle.
- Timing:
  - devREQO is registered and asserted from the first cycle in RD or WR.
  - devREQO is deasserted the cycle after devACKI.
  - One word costs at least 2 handshakes of 1 cycle each, plus 1 state-entry cycle.
- Timeout:
  - The counter is cleared on each RD/WR entry.
  - If the counter reaches TIMEOUT without devACKI: ERR <= 1, DONE <= 1, go to IDLE.
  - CNT, SRC and DST hold their values at the failure point.
- Interrupt:
  - devINTRO[BR] = DONE & IE, registered. All other devINTRO bits are 0.
- WRU:
  - wruhit = devREQI & WRU & (UBA# == UBANUM) & DONE & IE.
  - Returns devDATAO[18:35] = VECT. Does not clear DONE.
- devDATAO priority: register/vector read when devACKO; otherwise HOLD in WR; otherwise 0.
- Simultaneous events:
  - A register access in the same cycle as devACKI is serviced independently; both take effect.
  - DONE set (FIN) and a DONE W1C in the same cycle: the set wins.

Test Plan:
- Reset check: assert rst mid-DMA (CNT = 5, after 2 words) -> next cycle devREQO = 0, CSR/SRC/DST/CNT read 0, devINTRO = 0.
- Register read/write: write SRC = 18'o1000, DST = 18'o2000, CNT = 3 -> readback matches, devACKO high in the request cycle. A request to UBA# 1 gets no ack.
- Copy: UBA model acks after 2 cycles and returns words 1, 2, 3 -> three writes to 2000, 2002, 2004 with data 1, 2, 3. Final SRC = 1006, DST = 2006, CNT = 0. DONE = 1; BUSY = 0.
- Interrupt: IE = 1, CNT = 1 copy -> devINTRO[4] = 1. WRU poll on UBA# 3 -> devACKO = 1 and devDATAO = 300. Write CSR bit 7 = 1 -> devINTRO = 0.
- Zero count: GO with CNT = 0 -> no devREQO, DONE after 2 cycles.
- Timeout: UBA model never acks a RD -> ERR = 1, DONE = 1 after 1023 cycles, devREQO drops. A GO write during busy is ignored (SRC unchanged).
